// File: rtl/bht_ctrl.sv
// bht_ctrl: branch history table of 2-bit saturating counters with self-clearing init,
// registered prediction with same-cycle update bypass, and a saturating mispredict counter.
module bht_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ready,
   input  logic                 lk_valid,
   input  logic [31:0]          lk_pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   input  logic                 up_valid,
   input  logic [31:0]          up_pc,
   input  logic                 up_taken,
   output logic [CNT_WIDTH-1:0] mispred_cnt
);
   localparam int DEPTH = 1 << INDEX_BITS;
   typedef enum logic {INIT, RUN} state_e;
   state_e                state_q;
   logic [INDEX_BITS-1:0] init_idx_q, lk_idx, up_idx;
   logic [1:0]            tbl_q [DEPTH];
   logic [1:0]            up_old, up_new;
   logic                  ready_q, pred_valid_q, pred_taken_q, mis;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  unused_pc;
   assign unused_pc = ^{lk_pc[31:INDEX_BITS+2], lk_pc[1:0], up_pc[31:INDEX_BITS+2], up_pc[1:0]};
   always_comb begin
      lk_idx = lk_pc[INDEX_BITS+1:2];
      up_idx = up_pc[INDEX_BITS+1:2];
      up_old = tbl_q[up_idx];
      up_new = up_taken ? ((up_old == 2'b11) ? up_old : up_old + 2'd1)
                        : ((up_old == 2'b00) ? up_old : up_old - 2'd1);
      mis    = up_valid && (up_taken != up_old[1]);
      cnt_d  = (mis && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= INIT;
         init_idx_q   <= '0;
         ready_q      <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         cnt_q        <= '0;
      end else if (state_q == INIT) begin
         tbl_q[init_idx_q] <= 2'b00;
         init_idx_q        <= init_idx_q + 1'b1;
         pred_valid_q      <= 1'b0;
         if (init_idx_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
         end
      end else begin
         pred_valid_q <= lk_valid;
         // a same-index update in this cycle is forwarded so the prediction sees the new value
         if (lk_valid)
            pred_taken_q <= (up_valid && up_idx == lk_idx) ? up_new[1] : tbl_q[lk_idx][1];
         if (up_valid)
            tbl_q[up_idx] <= up_new;
         cnt_q <= cnt_d;
      end
   end
   assign ready       = ready_q;
   assign pred_valid  = pred_valid_q;
   assign pred_taken  = pred_taken_q;
   assign mispred_cnt = cnt_q;
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: directed tests of the branch history table controller.
module tb_bht_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lk_valid = 1'b0, up_valid = 1'b0, up_taken = 1'b0;
   logic [31:0] lk_pc = '0, up_pc = '0;
   logic        ready, pred_valid, pred_taken;
   logic [15:0] mispred_cnt;
   logic        ready4, pred_valid4, pred_taken4;
   logic [3:0]  mispred_cnt4;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   bht_ctrl #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .ready(ready), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .up_valid(up_valid),
      .up_pc(up_pc), .up_taken(up_taken), .mispred_cnt(mispred_cnt));

   bht_ctrl #(.INDEX_BITS(4), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .ready(ready4), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .pred_valid(pred_valid4), .pred_taken(pred_taken4), .up_valid(up_valid),
      .up_pc(up_pc), .up_taken(up_taken), .mispred_cnt(mispred_cnt4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic do_update(input logic [31:0] pc, input logic t);
      up_valid = 1'b1;
      up_pc    = pc;
      up_taken = t;
      tick();
      up_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [31:0] pc, output logic pv, output logic pt);
      lk_valid = 1'b1;
      lk_pc    = pc;
      tick();
      lk_valid = 1'b0;
      pv = pred_valid;
      pt = pred_taken;
   endtask

   task automatic test_reset();
      int n;
      logic pv, pt;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (ready !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || mispred_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state got r=%b pv=%b pt=%b cnt=%0d exp 0 0 0 0", ready, pred_valid, pred_taken, mispred_cnt);
      end
      wait_ready(n);
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL init_len got %0d exp 16", n);
      end
      for (int i = 0; i < 16; i++) begin
         do_lookup(32'(i) << 2, pv, pt);
         checks++;
         if (pv !== 1'b1 || pt !== 1'b0) begin
            errors++;
            $display("FAIL init_entry%0d got pv=%b pt=%b exp pv=1 pt=0", i, pv, pt);
         end
      end
      tick();
      checks++;
      if (pred_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_pv got %b exp 0", pred_valid);
      end
   endtask

   task automatic test_counter();
      logic pv, pt;
      do_update(32'h10, 1'b1);
      do_update(32'h10, 1'b1);
      do_update(32'h10, 1'b1);
      do_update(32'h10, 1'b0);
      do_lookup(32'h10, pv, pt);
      checks++;
      if (pv !== 1'b1 || pt !== 1'b1 || mispred_cnt !== 16'd3) begin
         errors++;
         $display("FAIL seq_0x10 got pv=%b pt=%b cnt=%0d exp 1 1 3", pv, pt, mispred_cnt);
      end
      do_update(32'h10, 1'b0);
      do_update(32'h10, 1'b0);
      do_update(32'h10, 1'b0);
      do_update(32'h10, 1'b1);
      do_lookup(32'h10, pv, pt);
      checks++;
      if (pt !== 1'b0 || mispred_cnt !== 16'd5) begin
         errors++;
         $display("FAIL sat_low got pt=%b cnt=%0d exp 0 5", pt, mispred_cnt);
      end
      for (int i = 0; i < 4; i++) do_update(32'h14, 1'b1);
      do_update(32'h14, 1'b0);
      do_lookup(32'h14, pv, pt);
      checks++;
      if (pt !== 1'b1 || mispred_cnt !== 16'd8) begin
         errors++;
         $display("FAIL sat_high got pt=%b cnt=%0d exp 1 8", pt, mispred_cnt);
      end
   endtask

   task automatic test_bypass();
      do_update(32'h24, 1'b1);
      lk_valid = 1'b1; lk_pc = 32'h24;
      do_update(32'h24, 1'b1);
      lk_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL bypass_t got pv=%b pt=%b exp 1 1", pred_valid, pred_taken);
      end
      lk_valid = 1'b1;
      do_update(32'h24, 1'b0);
      lk_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || mispred_cnt !== 16'd11) begin
         errors++;
         $display("FAIL bypass_nt got pv=%b pt=%b cnt=%0d exp 1 0 11", pred_valid, pred_taken, mispred_cnt);
      end
   endtask

   task automatic test_diff_index();
      logic pv, pt;
      lk_valid = 1'b1; lk_pc = 32'h14;
      do_update(32'h18, 1'b0);
      lk_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || mispred_cnt !== 16'd11) begin
         errors++;
         $display("FAIL diff_idx got pv=%b pt=%b cnt=%0d exp 1 1 11", pred_valid, pred_taken, mispred_cnt);
      end
      do_lookup(32'h18, pv, pt);
      checks++;
      if (pt !== 1'b0) begin
         errors++;
         $display("FAIL diff_idx_up got pt=%b exp 0", pt);
      end
   endtask

   task automatic test_init_ignore();
      int n = 0;
      logic bad = 1'b0, pv, pt;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      lk_valid = 1'b1; lk_pc = 32'h10;
      up_valid = 1'b1; up_pc = 32'h10; up_taken = 1'b1;
      while (!ready && n < 100) begin
         tick();
         n++;
         if (pred_valid !== 1'b0) bad = 1'b1;
      end
      lk_valid = 1'b0; up_valid = 1'b0;
      checks++;
      if (bad !== 1'b0 || mispred_cnt !== 16'd0 || n !== 16) begin
         errors++;
         $display("FAIL init_ignore got bad_pv=%b cnt=%0d n=%0d exp 0 0 16", bad, mispred_cnt, n);
      end
      for (int i = 0; i < 16; i++) begin
         do_lookup(32'(i) << 2, pv, pt);
         if (pt !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL init_ignore_tbl got nonzero entry exp all 0");
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic bad = 1'b0, pv, pt;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (8) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      wait_ready(n);
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL reset_mid_init got %0d exp 16", n);
      end
      do_update(32'h10, 1'b1);
      do_update(32'h10, 1'b1);
      checks++;
      if (mispred_cnt !== 16'd2) begin
         errors++;
         $display("FAIL run_updates got %0d exp 2", mispred_cnt);
      end
      reset = 1'b0;
      lk_valid = 1'b1; lk_pc = 32'h10;
      up_valid = 1'b1; up_pc = 32'h10; up_taken = 1'b0;
      tick();
      reset = 1'b1; lk_valid = 1'b0; up_valid = 1'b0;
      checks++;
      if (ready !== 1'b0 || pred_valid !== 1'b0 || mispred_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_run got r=%b pv=%b cnt=%0d exp 0 0 0", ready, pred_valid, mispred_cnt);
      end
      wait_ready(n);
      for (int i = 0; i < 16; i++) begin
         do_lookup(32'(i) << 2, pv, pt);
         if (pt !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (n !== 16 || bad !== 1'b0 || mispred_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_run_init got n=%0d bad=%b cnt=%0d exp 16 0 0", n, bad, mispred_cnt);
      end
   endtask

   task automatic test_saturation();
      do_update(32'h30, 1'b1);
      do_update(32'h30, 1'b1);
      for (int i = 0; i < 9; i++) begin
         do_update(32'h30, 1'b0);
         do_update(32'h30, 1'b1);
      end
      checks++;
      if (mispred_cnt !== 16'd20 || mispred_cnt4 !== 4'hF) begin
         errors++;
         $display("FAIL cnt_sat got w16=%0d w4=%0h exp 20 f", mispred_cnt, mispred_cnt4);
      end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_bypass();
      test_diff_index();
      test_init_ignore();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
